// File: rtl/chunk_adder.sv
// Multi-cycle adder: one CHUNK-bit slice of A+B+carry per clock, carry held in a register.
// Optional subtract mode (Sub port) is enabled by defining CHUNK_ADDER_SUB_EN.
//
// state  | meaning
// IDLE   | ready for operands
// RUN    | adding one slice per cycle, LSB first
// DONE   | result presented, waiting for consumer
module chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
`ifdef CHUNK_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic             w_sub;
  logic             w_accept;
  logic             w_last;
  logic [31:0]      w_base;
  logic [CHUNK-1:0] w_a_sl;
  logic [CHUNK-1:0] w_b_sl;
  logic [CHUNK:0]   w_sum;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_acc_nxt;

`ifdef CHUNK_ADDER_SUB_EN
  assign w_sub = i_sub;
`else
  assign w_sub = 1'b0;
`endif

  assign w_accept = i_in_valid && (r_state == S_IDLE);
  assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);
  assign w_base   = 32'(r_cnt) * CHUNK;

  always_comb begin
    w_a_sl = r_a[w_base +: CHUNK];
    w_b_sl = r_b[w_base +: CHUNK];
    w_sum  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, r_carry};
    // carry into the top bit of the slice, recovered from its sum bit
    w_cmsb = w_a_sl[CHUNK-1] ^ w_b_sl[CHUNK-1] ^ w_sum[CHUNK-1];
    w_acc_nxt = r_acc;
    w_acc_nxt[w_base +: CHUNK] = w_sum[CHUNK-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)      w_state_nxt = S_DONE;
      S_DONE:  if (i_out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready  = (r_state == S_IDLE);
    o_out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= w_sub ? ~i_b : i_b;
      r_carry <= i_cin ^ w_sub;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_acc   <= w_acc_nxt;
      r_carry <= w_sum[CHUNK];
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_s    <= w_acc_nxt;
        r_cout <= w_sum[CHUNK];
        r_ovf  <= w_cmsb ^ w_sum[CHUNK];
      end
    end
  end

  assign o_s    = r_s;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_chunk_adder.sv
// Directed and swept checks of chunk_adder at CHUNK = 4, 1 and 16 (WIDTH = 16).
module tb_chunk_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a, b;
  logic        cin, sub;
  logic        in_valid [3];
  logic        in_ready [3];
  logic        out_valid[3];
  logic        out_ready[3];
  logic [15:0] s        [3];
  logic        cout     [3];
  logic        ovf      [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  chunk_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
    .i_a(a), .i_b(b), .i_cin(cin),
`ifdef CHUNK_ADDER_SUB_EN
    .i_sub(sub),
`endif
    .o_out_valid(out_valid[0]), .i_out_ready(out_ready[0]),
    .o_s(s[0]), .o_cout(cout[0]), .o_ovf(ovf[0]));

  chunk_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
    .i_a(a), .i_b(b), .i_cin(cin),
`ifdef CHUNK_ADDER_SUB_EN
    .i_sub(sub),
`endif
    .o_out_valid(out_valid[1]), .i_out_ready(out_ready[1]),
    .o_s(s[1]), .o_cout(cout[1]), .o_ovf(ovf[1]));

  chunk_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[2]), .o_in_ready(in_ready[2]),
    .i_a(a), .i_b(b), .i_cin(cin),
`ifdef CHUNK_ADDER_SUB_EN
    .i_sub(sub),
`endif
    .o_out_valid(out_valid[2]), .i_out_ready(out_ready[2]),
    .o_s(s[2]), .o_cout(cout[2]), .o_ovf(ovf[2]));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // all tasks start and end 1 time unit after a rising edge
  task automatic start_op(input int k, input logic [15:0] va, input logic [15:0] vb,
                          input logic vc, input logic vs);
    int n = 0;
    while (!in_ready[k] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready[k]) timeout_fail("start_op");
    a = va; b = vb; cin = vc; sub = vs;
    in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (!out_valid[k] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid[k]) timeout_fail("wait_done");
  endtask

  task automatic take(input int k);
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
  endtask

  initial begin
    int          lat;
    logic        seen;
    logic [15:0] ra, rb, bb;
    logic        rc, rs, cc;
    logic [16:0] full;
    int          exp_lat;

    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
    end
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0});
`ifdef CHUNK_ADDER_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

    #12;
    check("reset_in_ready",  32'(in_ready[0]),  32'd1);
    check("reset_out_valid", 32'(out_valid[0]), 32'd0);
    check("reset_s",         32'(s[0]),         32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      start_op(0, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      wait_done(0, lat);
      check($sformatf("vec%0d_lat", i),  32'(lat),     32'd4);
      check($sformatf("vec%0d_s", i),    32'(s[0]),    32'(vecs[i].s));
      check($sformatf("vec%0d_cout", i), 32'(cout[0]), 32'(vecs[i].co));
      check($sformatf("vec%0d_ovf", i),  32'(ovf[0]),  32'(vecs[i].ov));
      take(0);
    end

    // backpressure, ignored In_valid pulses, re-accept two edges after handshake
    start_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    a = 16'hFFFF; b = 16'hFFFF; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    wait_done(0, lat);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_out_valid", i), 32'(out_valid[0]), 32'd1);
      check($sformatf("bp%0d_in_ready", i),  32'(in_ready[0]),  32'd0);
      check($sformatf("bp%0d_s", i),         32'(s[0]),         32'h0100);
      check($sformatf("bp%0d_cout_ovf", i),  32'({cout[0], ovf[0]}), 32'd0);
      @(posedge clk); #1;
    end
    take(0);
    check("hs_in_ready",  32'(in_ready[0]),  32'd1);
    check("hs_out_valid", 32'(out_valid[0]), 32'd0);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    check("reaccept_in_ready", 32'(in_ready[0]), 32'd0);
    wait_done(0, lat);
    check("reaccept_lat", 32'(lat),  32'd4);
    check("reaccept_s",   32'(s[0]), 32'h3333);
    take(0);

    // asynchronous reset two cycles into RUN
    start_op(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready",  32'(in_ready[0]),  32'd1);
    check("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_s",         32'(s[0]),         32'd0);
    check("rst_cout",      32'(cout[0]),      32'd0);
    check("rst_ovf",       32'(ovf[0]),       32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | out_valid[0];
      @(posedge clk); #1;
    end
    check("rst_no_out_valid", 32'(seen), 32'd0);
    start_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_done(0, lat);
    check("post_rst_s", 32'(s[0]), 32'h2345);
    take(0);

    // random back-to-back sweep across chunk sizes
    for (int k = 0; k < 3; k++) begin
      exp_lat = (k == 0) ? 4 : (k == 1) ? 16 : 1;
      for (int i = 0; i < 6; i++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom_range(1, 0));
`ifdef CHUNK_ADDER_SUB_EN
        rs = 1'($urandom_range(1, 0));
`else
        rs = 1'b0;
`endif
        bb   = rs ? ~rb : rb;
        cc   = rs ? ~rc : rc;
        full = {1'b0, ra} + {1'b0, bb} + {16'd0, cc};
        start_op(k, ra, rb, rc, rs);
        wait_done(k, lat);
        check($sformatf("sw%0d_%0d_lat", k, i),  32'(lat),     32'(exp_lat));
        check($sformatf("sw%0d_%0d_s", k, i),    32'(s[k]),    32'(full[15:0]));
        check($sformatf("sw%0d_%0d_cout", k, i), 32'(cout[k]), 32'(full[16]));
        check($sformatf("sw%0d_%0d_ovf", k, i),  32'(ovf[k]),
              32'((ra[15] == bb[15]) && (full[15] != ra[15])));
        take(k);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
